// File: rtl/gme_mc.sv
// rtl/gme_mc.sv - match/pass stage: forwards keys to lookup, merges lookup result into MD
module gme_mc_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [W-1:0]          wdata,
  input  logic                  rd,
  output logic [W-1:0]          rdata,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   used,
  output logic                  ovf
);
  logic [W-1:0]          mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;

  // used tops out at exactly 2^DEPTH_LOG2, so its MSB alone means full
  assign full  = used[DEPTH_LOG2];
  assign empty = (used == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign ovf   = wr & full;
  assign rdata = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      used <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end
endmodule

module gme_mc #(
  parameter int         MD_W       = 256,
  parameter int         PHV_W      = 1024,
  parameter int         KEY_W      = 512,
  parameter int         IDX_W      = 13,
  parameter int         DEPTH_LOG2 = 8,
  parameter int         MID_LSB    = 80,
  parameter int         IDX_LSB    = 50,
  parameter logic [7:0] LMID       = 8'd3,
  parameter logic [7:0] NMID       = 8'd4,
  parameter bit         MISS_DROP  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_key_wr,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_key_alf,
  input  logic               in_md_wr,
  input  logic [MD_W-1:0]    in_md,
  input  logic               in_phv_wr,
  input  logic [PHV_W-1:0]   in_phv,
  output logic               out_md_alf,
  output logic               out_phv_alf,
  input  logic               in_idx_wr,
  input  logic [IDX_W:0]     in_idx,
  output logic               out_idx_alf,
  output logic               out_key_wr,
  output logic [KEY_W-1:0]   out_key,
  input  logic               in_key_alf,
  output logic               out_md_wr,
  output logic [MD_W-1:0]    out_md,
  output logic               out_phv_wr,
  output logic [PHV_W-1:0]   out_phv,
  input  logic               in_md_alf,
  input  logic               in_phv_alf,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
  output logic [31:0]        drop_cnt,
  output logic               ovf_err
);
  if (MID_LSB + 8 > MD_W || IDX_LSB + IDX_W + 1 > MD_W) begin : g_cfg_err
    $error("gme_mc: MID or index field does not fit inside MD_W");
  end

  localparam logic [DEPTH_LOG2:0] ALF_TH = (DEPTH_LOG2 + 1)'((1 << DEPTH_LOG2) - 6);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IDX, S_EMIT} state_t;
  state_t state, nxt;

  logic [MD_W-1:0]     md_head;
  logic [PHV_W-1:0]    phv_head;
  logic [IDX_W:0]      idx_head;
  logic                md_empty, phv_empty, idx_empty;
  logic [DEPTH_LOG2:0] md_used, phv_used, idx_used;
  logic                md_ovf, phv_ovf, idx_ovf;
  logic                pop_pkt, pop_idx;
  logic [MD_W-1:0]     hold_md;
  logic [PHV_W-1:0]    hold_phv;
  logic [IDX_W:0]      hold_idx;
  logic                hold_match;
  logic [MD_W-1:0]     md_mod;
  logic                emit_wr;
  logic                key_hit;

  gme_mc_fifo #(.W(MD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_md_fifo (
    .clk(clk), .rst(rst), .wr(in_md_wr), .wdata(in_md), .rd(pop_pkt),
    .rdata(md_head), .empty(md_empty), .used(md_used), .ovf(md_ovf));
  gme_mc_fifo #(.W(PHV_W), .DEPTH_LOG2(DEPTH_LOG2)) u_phv_fifo (
    .clk(clk), .rst(rst), .wr(in_phv_wr), .wdata(in_phv), .rd(pop_pkt),
    .rdata(phv_head), .empty(phv_empty), .used(phv_used), .ovf(phv_ovf));
  gme_mc_fifo #(.W(IDX_W + 1), .DEPTH_LOG2(DEPTH_LOG2)) u_idx_fifo (
    .clk(clk), .rst(rst), .wr(in_idx_wr), .wdata(in_idx), .rd(pop_idx),
    .rdata(idx_head), .empty(idx_empty), .used(idx_used), .ovf(idx_ovf));

  assign out_key_alf = in_key_alf;
  assign out_md_alf  = in_md_alf | (md_used > ALF_TH);
  assign out_phv_alf = in_phv_alf | (phv_used > ALF_TH);
  assign out_idx_alf = (idx_used > ALF_TH);
  assign key_hit     = in_key_wr && (in_md[MID_LSB +: 8] == LMID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // A matched packet stays at the FIFO heads until its lookup result arrives
  always_comb begin
    nxt     = state;
    pop_pkt = 1'b0;
    pop_idx = 1'b0;
    case (state)
      S_IDLE: begin
        if (!md_empty && !phv_empty && !in_md_alf && !in_phv_alf) begin
          if (md_head[MID_LSB +: 8] == LMID) begin
            nxt = S_WAIT_IDX;
          end else begin
            pop_pkt = 1'b1;
            nxt     = S_EMIT;
          end
        end
      end
      S_WAIT_IDX: begin
        if (!idx_empty) begin
          pop_pkt = 1'b1;
          pop_idx = 1'b1;
          nxt     = S_EMIT;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    md_mod = hold_md;
    if (hold_match) begin
      md_mod[MID_LSB +: 8]     = NMID;
      md_mod[IDX_LSB +: IDX_W] = hold_idx[IDX_W-1:0];
      md_mod[IDX_LSB + IDX_W]  = hold_idx[IDX_W];
    end
  end

  assign emit_wr = (state == S_EMIT) && !(hold_match && !hold_idx[IDX_W] && MISS_DROP);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_md    <= '0;
      hold_phv   <= '0;
      hold_idx   <= '0;
      hold_match <= 1'b0;
      out_key_wr <= 1'b0;
      out_key    <= '0;
      out_md_wr  <= 1'b0;
      out_phv_wr <= 1'b0;
      out_md     <= '0;
      out_phv    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      drop_cnt   <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (pop_pkt) begin
        hold_md    <= md_head;
        hold_phv   <= phv_head;
        hold_idx   <= idx_head;
        hold_match <= (state == S_WAIT_IDX);
      end
      out_key_wr <= key_hit;
      if (key_hit) out_key <= in_key;
      out_md_wr  <= emit_wr;
      out_phv_wr <= emit_wr;
      out_md     <= emit_wr ? md_mod : '0;
      out_phv    <= emit_wr ? hold_phv : '0;
      if (state == S_EMIT && hold_match) begin
        if (hold_idx[IDX_W]) begin
          hit_cnt <= sat_inc(hit_cnt);
        end else begin
          miss_cnt <= sat_inc(miss_cnt);
          if (MISS_DROP) drop_cnt <= sat_inc(drop_cnt);
        end
      end
      if (md_ovf || phv_ovf || idx_ovf) ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gme_mc.sv
// tb/tb_gme_mc.sv - randomized self-checking bench for gme_mc against a packet-level model
module tb_gme_mc;
  localparam int MD_W = 256, PHV_W = 1024, KEY_W = 512, IDX_W = 13;
  localparam int MID_LSB = 80, IDX_LSB = 50;
  localparam logic [7:0] LMID = 8'd3, NMID = 8'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic             in_key_wr = 0, in_md_wr = 0, in_phv_wr = 0, in_idx_wr = 0;
  logic [KEY_W-1:0] in_key = '0;
  logic [MD_W-1:0]  in_md = '0;
  logic [PHV_W-1:0] in_phv = '0;
  logic [IDX_W:0]   in_idx = '0;
  logic             in_key_alf = 0, in_md_alf = 0, in_phv_alf = 0;

  logic             out_key_alf, out_md_alf, out_phv_alf, out_idx_alf, out_key_wr;
  logic [KEY_W-1:0] out_key;
  logic             out_md_wr, out_phv_wr, ovf_err;
  logic [MD_W-1:0]  out_md;
  logic [PHV_W-1:0] out_phv;
  logic [31:0]      hit_cnt, miss_cnt, drop_cnt;

  logic             d_key_alf, d_md_alf, d_phv_alf, d_idx_alf, d_key_wr;
  logic [KEY_W-1:0] d_key;
  logic             d_md_wr, d_phv_wr, d_ovf_err;
  logic [MD_W-1:0]  d_md;
  logic [PHV_W-1:0] d_phv;
  logic [31:0]      d_hit_cnt, d_miss_cnt, d_drop_cnt;

  gme_mc dut (
    .clk(clk), .rst(rst), .in_key_wr(in_key_wr), .in_key(in_key), .out_key_alf(out_key_alf),
    .in_md_wr(in_md_wr), .in_md(in_md), .in_phv_wr(in_phv_wr), .in_phv(in_phv),
    .out_md_alf(out_md_alf), .out_phv_alf(out_phv_alf), .in_idx_wr(in_idx_wr), .in_idx(in_idx),
    .out_idx_alf(out_idx_alf), .out_key_wr(out_key_wr), .out_key(out_key), .in_key_alf(in_key_alf),
    .out_md_wr(out_md_wr), .out_md(out_md), .out_phv_wr(out_phv_wr), .out_phv(out_phv),
    .in_md_alf(in_md_alf), .in_phv_alf(in_phv_alf), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .drop_cnt(drop_cnt), .ovf_err(ovf_err));

  gme_mc #(.MISS_DROP(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_key_wr(in_key_wr), .in_key(in_key), .out_key_alf(d_key_alf),
    .in_md_wr(in_md_wr), .in_md(in_md), .in_phv_wr(in_phv_wr), .in_phv(in_phv),
    .out_md_alf(d_md_alf), .out_phv_alf(d_phv_alf), .in_idx_wr(in_idx_wr), .in_idx(in_idx),
    .out_idx_alf(d_idx_alf), .out_key_wr(d_key_wr), .out_key(d_key), .in_key_alf(in_key_alf),
    .out_md_wr(d_md_wr), .out_md(d_md), .out_phv_wr(d_phv_wr), .out_phv(d_phv),
    .in_md_alf(in_md_alf), .in_phv_alf(in_phv_alf), .hit_cnt(d_hit_cnt), .miss_cnt(d_miss_cnt),
    .drop_cnt(d_drop_cnt), .ovf_err(d_ovf_err));

  int errors = 0;
  int checks = 0;

  logic [MD_W-1:0]  got_md[$], dgot_md[$];
  logic [PHV_W-1:0] got_phv[$], dgot_phv[$];
  logic [KEY_W-1:0] got_key[$];
  int               got_cyc[$];
  int               strobe_bad = 0, zero_bad = 0;

  always @(negedge clk) begin
    if (out_md_wr) begin got_md.push_back(out_md); got_phv.push_back(out_phv); got_cyc.push_back(cyc); end
    if (d_md_wr) begin dgot_md.push_back(d_md); dgot_phv.push_back(d_phv); end
    if (out_key_wr) got_key.push_back(out_key);
    if (out_md_wr !== out_phv_wr || d_md_wr !== d_phv_wr) strobe_bad++;
    if ((!out_md_wr && (out_md !== '0 || out_phv !== '0)) || (!d_md_wr && (d_md !== '0 || d_phv !== '0)))
      zero_bad++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_md.delete(); got_phv.delete(); got_cyc.delete(); got_key.delete();
    dgot_md.delete(); dgot_phv.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    clear_q();
  endtask

  function automatic logic [MD_W-1:0] rnd_md(input logic [7:0] mid);
    logic [MD_W-1:0] r;
    for (int i = 0; i < MD_W / 32; i++) r[i*32 +: 32] = $urandom;
    r[MID_LSB +: 8] = mid;
    return r;
  endfunction

  function automatic logic [PHV_W-1:0] rnd_phv();
    logic [PHV_W-1:0] r;
    for (int i = 0; i < PHV_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] rnd_key();
    logic [KEY_W-1:0] r;
    for (int i = 0; i < KEY_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] rnd_other_mid();
    logic [7:0] m;
    do m = 8'($urandom); while (m == LMID);
    return m;
  endfunction

  // Expected MD after a match: clear MID and {hit,idx} fields, then OR in the new values
  function automatic logic [MD_W-1:0] exp_match(input logic [MD_W-1:0] md, input logic hit,
                                                input logic [IDX_W-1:0] idx);
    logic [MD_W-1:0] keep;
    keep = ~((MD_W'(8'hFF) << MID_LSB) | (((MD_W'(1) << (IDX_W + 1)) - MD_W'(1)) << IDX_LSB));
    return (md & keep) | (MD_W'(NMID) << MID_LSB) | (MD_W'({hit, idx}) << IDX_LSB);
  endfunction

  task automatic push_pkt(input logic [MD_W-1:0] md, input logic [PHV_W-1:0] phv,
                          input logic with_key, input logic [KEY_W-1:0] key);
    in_md = md; in_md_wr = 1'b1; in_phv = phv; in_phv_wr = 1'b1;
    in_key = key; in_key_wr = with_key;
    step();
    in_md_wr = 1'b0; in_phv_wr = 1'b0; in_key_wr = 1'b0;
  endtask

  task automatic push_idx(input logic hit, input logic [IDX_W-1:0] idx);
    in_idx = {hit, idx}; in_idx_wr = 1'b1;
    step();
    in_idx_wr = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget, input string name);
    int k = 0;
    while (got_md.size() < n && k < budget) begin step(); k++; end
    checks++;
    if (got_md.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, got_md.size(), n);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_md_wr !== 1'b0 || out_phv_wr !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b%b expected 00", out_md_wr, out_phv_wr); end
    checks++; if (out_key_wr !== 1'b0) begin errors++; $display("FAIL reset_key_wr: got %b expected 0", out_key_wr); end
    checks++; if (hit_cnt !== 0 || miss_cnt !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", hit_cnt, miss_cnt, drop_cnt); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_err); end
    checks++; if (out_md_alf !== 1'b0 || out_phv_alf !== 1'b0 || out_idx_alf !== 1'b0) begin errors++; $display("FAIL reset_alf: got %b%b%b expected 000", out_md_alf, out_phv_alf, out_idx_alf); end
    in_key_alf = 1'b1; #1;
    checks++; if (out_key_alf !== 1'b1) begin errors++; $display("FAIL key_alf_hi: got %b expected 1", out_key_alf); end
    in_key_alf = 1'b0; #1;
    checks++; if (out_key_alf !== 1'b0) begin errors++; $display("FAIL key_alf_lo: got %b expected 0", out_key_alf); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_pass();
    logic [MD_W-1:0] md;
    logic [PHV_W-1:0] phv;
    int w;
    clear_q();
    md = rnd_md(8'd7); phv = rnd_phv();
    push_pkt(md, phv, 1'b1, rnd_key());
    w = cyc;
    wait_n(1, 20, "pass");
    step(); step();
    checks++; if (got_md.size() != 1 || got_md[0] !== md) begin errors++; $display("FAIL pass_md: got %0d outputs, first %h expected %h", got_md.size(), got_md.size() ? got_md[0] : '0, md); end
    checks++; if (got_phv.size() != 1 || got_phv[0][63:0] !== phv[63:0] || got_phv[0] !== phv) begin errors++; $display("FAIL pass_phv: got %h expected %h (low 64 bits)", got_phv.size() ? got_phv[0][63:0] : 64'h0, phv[63:0]); end
    checks++; if (got_cyc.size() < 1 || got_cyc[0] != w + 2) begin errors++; $display("FAIL pass_latency: got cycle %0d expected %0d", got_cyc.size() ? got_cyc[0] : -1, w + 2); end
    checks++; if (got_key.size() != 0) begin errors++; $display("FAIL pass_no_key: got %0d key strobes expected 0", got_key.size()); end
  endtask

  task automatic test_match_hit();
    logic [MD_W-1:0] md;
    logic [PHV_W-1:0] phv;
    logic [KEY_W-1:0] key;
    do_reset();
    md = rnd_md(LMID); phv = rnd_phv(); key = rnd_key();
    push_pkt(md, phv, 1'b1, key);
    checks++; if (out_key_wr !== 1'b1 || out_key !== key) begin errors++; $display("FAIL hit_key: got wr=%b key %h expected wr=1 key %h", out_key_wr, out_key[63:0], key[63:0]); end
    step();
    checks++; if (out_key_wr !== 1'b0) begin errors++; $display("FAIL hit_key_pulse: got %b expected 0", out_key_wr); end
    step(); step(); step();
    checks++; if (got_md.size() != 0) begin errors++; $display("FAIL hit_wait_idx: got %0d outputs expected 0", got_md.size()); end
    push_idx(1'b1, 13'h1A5);
    wait_n(1, 20, "hit");
    step(); step();
    if (got_md.size() >= 1) begin
      checks++; if (got_md[0][87:80] !== 8'd4 || got_md[0][62:50] !== 13'h1A5 || got_md[0][63] !== 1'b1) begin errors++; $display("FAIL hit_fields: got mid %h idx %h hit %b expected 04 1a5 1", got_md[0][87:80], got_md[0][62:50], got_md[0][63]); end
      checks++; if (got_md[0] !== exp_match(md, 1'b1, 13'h1A5)) begin errors++; $display("FAIL hit_md: got %h expected %h", got_md[0], exp_match(md, 1'b1, 13'h1A5)); end
      checks++; if (got_phv[0] !== phv) begin errors++; $display("FAIL hit_phv: got %h expected %h (low 64 bits)", got_phv[0][63:0], phv[63:0]); end
    end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd0) begin errors++; $display("FAIL hit_cnt: got %0d/%0d expected 1/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_match_miss();
    logic [MD_W-1:0] md;
    logic [IDX_W-1:0] idx;
    do_reset();
    md = rnd_md(LMID); idx = IDX_W'($urandom);
    push_pkt(md, rnd_phv(), 1'b1, rnd_key());
    push_idx(1'b0, idx);
    wait_n(1, 20, "miss");
    step(); step(); step(); step();
    checks++; if (got_md.size() != 1 || got_md[0] !== exp_match(md, 1'b0, idx)) begin errors++; $display("FAIL miss_md: got %0d outputs first %h expected %h", got_md.size(), got_md.size() ? got_md[0] : '0, exp_match(md, 1'b0, idx)); end
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL miss_cnt: got %0d/%0d/%0d expected 1/0/0", miss_cnt, hit_cnt, drop_cnt); end
    checks++; if (dgot_md.size() != 0) begin errors++; $display("FAIL drop_no_emit: got %0d outputs expected 0", dgot_md.size()); end
    checks++; if (d_drop_cnt !== 32'd1 || d_miss_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt: got drop %0d miss %0d expected 1 1", d_drop_cnt, d_miss_cnt); end
  endtask

  task automatic test_backpressure();
    logic [MD_W-1:0] mds[3];
    logic [PHV_W-1:0] phvs[3];
    do_reset();
    in_md_alf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mds[i] = rnd_md(rnd_other_mid()); phvs[i] = rnd_phv();
      push_pkt(mds[i], phvs[i], 1'b0, '0);
    end
    for (int i = 0; i < 10; i++) step();
    checks++; if (got_md.size() != 0) begin errors++; $display("FAIL bp_hold: got %0d outputs expected 0", got_md.size()); end
    checks++; if (out_md_alf !== 1'b1) begin errors++; $display("FAIL bp_alf: got %b expected 1", out_md_alf); end
    in_md_alf = 1'b0;
    wait_n(3, 40, "bp");
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_md.size() <= i || got_md[i] !== mds[i] || got_phv[i] !== phvs[i]) begin
        errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got_md.size() > i ? got_md[i] : '0, mds[i]);
      end
    end
  endtask

  logic [MD_W-1:0]  ov_md[257];
  logic [PHV_W-1:0] ov_phv[256];

  task automatic test_overflow();
    int bad;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      ov_md[i] = rnd_md(8'd7);
      in_md = ov_md[i]; in_md_wr = 1'b1;
      step();
      if (i + 1 == 250) begin checks++; if (out_md_alf !== 1'b0) begin errors++; $display("FAIL ovf_alf250: got %b expected 0", out_md_alf); end end
      if (i + 1 == 251) begin checks++; if (out_md_alf !== 1'b1) begin errors++; $display("FAIL ovf_alf251: got %b expected 1", out_md_alf); end end
      if (i + 1 == 256) begin checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf_err); end end
    end
    in_md_wr = 1'b0;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_err); end
    for (int i = 0; i < 256; i++) begin
      ov_phv[i] = rnd_phv();
      in_phv = ov_phv[i]; in_phv_wr = 1'b1;
      step();
    end
    in_phv_wr = 1'b0;
    wait_n(256, 800, "ovf");
    for (int i = 0; i < 6; i++) step();
    checks++; if (got_md.size() != 256) begin errors++; $display("FAIL ovf_count: got %0d outputs expected 256", got_md.size()); end
    bad = 0;
    for (int i = 0; i < 256 && i < got_md.size(); i++)
      if (got_md[i] !== ov_md[i] || got_phv[i] !== ov_phv[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_order: got %0d mismatching packets expected 0", bad); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
  endtask

  task automatic test_reset_wait_idx();
    logic [MD_W-1:0] md_a, md_b;
    logic [IDX_W-1:0] idx;
    clear_q();
    push_pkt(rnd_md(LMID), rnd_phv(), 1'b1, rnd_key());
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++; if (out_md_wr !== 0 || out_md !== '0 || out_phv !== '0 || out_key_wr !== 0 || out_key !== '0) begin errors++; $display("FAIL rst_outputs: got md_wr=%b key_wr=%b key %h expected all zero", out_md_wr, out_key_wr, out_key[63:0]); end
    checks++; if (ovf_err !== 1'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin errors++; $display("FAIL rst_state: got ovf=%b hit=%0d miss=%0d expected 0 0 0", ovf_err, hit_cnt, miss_cnt); end
    step(); step();
    rst = 1'b0;
    step();
    clear_q();
    md_a = rnd_md(rnd_other_mid());
    push_pkt(md_a, rnd_phv(), 1'b0, '0);
    md_b = rnd_md(LMID); idx = IDX_W'($urandom);
    push_pkt(md_b, rnd_phv(), 1'b1, rnd_key());
    push_idx(1'b1, idx);
    wait_n(2, 30, "rst_after");
    for (int i = 0; i < 5; i++) step();
    checks++; if (got_md.size() != 2 || got_md[0] !== md_a) begin errors++; $display("FAIL rst_next_pass: got %0d outputs first %h expected %h", got_md.size(), got_md.size() ? got_md[0] : '0, md_a); end
    checks++; if (got_md.size() < 2 || got_md[1] !== exp_match(md_b, 1'b1, idx)) begin errors++; $display("FAIL rst_next_match: got %h expected %h", got_md.size() > 1 ? got_md[1] : '0, exp_match(md_b, 1'b1, idx)); end
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL rst_next_hit: got %0d expected 1", hit_cnt); end
  endtask

  task automatic test_random();
    logic [MD_W-1:0]  exp_md[$], dexp_md[$];
    logic [PHV_W-1:0] exp_phv[$], dexp_phv[$];
    logic [KEY_W-1:0] exp_key[$];
    logic [MD_W-1:0]  md;
    logic [PHV_W-1:0] phv;
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] idx;
    logic             hit, is_match;
    int               n_hit = 0, n_miss = 0, n = 24;
    do_reset();
    for (int p = 0; p < n; p++) begin
      is_match = ($urandom_range(0, 1) == 1);
      md = rnd_md(is_match ? LMID : rnd_other_mid()); phv = rnd_phv(); key = rnd_key();
      push_pkt(md, phv, is_match ? 1'b1 : 1'($urandom_range(0, 1)), key);
      if (is_match) begin
        hit = 1'($urandom_range(0, 1)); idx = IDX_W'($urandom);
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
        push_idx(hit, idx);
        exp_key.push_back(key);
        exp_md.push_back(exp_match(md, hit, idx)); exp_phv.push_back(phv);
        if (hit) begin n_hit++; dexp_md.push_back(exp_match(md, hit, idx)); dexp_phv.push_back(phv); end
        else n_miss++;
      end else begin
        exp_md.push_back(md); exp_phv.push_back(phv);
        dexp_md.push_back(md); dexp_phv.push_back(phv);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
    end
    wait_n(n, 600, "rand");
    for (int i = 0; i < 10; i++) step();
    checks++; if (got_md.size() != exp_md.size() || dgot_md.size() != dexp_md.size()) begin errors++; $display("FAIL rand_count: got %0d/%0d expected %0d/%0d", got_md.size(), dgot_md.size(), exp_md.size(), dexp_md.size()); end
    for (int i = 0; i < exp_md.size() && i < got_md.size(); i++) begin
      checks++; if (got_md[i] !== exp_md[i] || got_phv[i] !== exp_phv[i]) begin errors++; $display("FAIL rand_pkt%0d: got %h expected %h", i, got_md[i], exp_md[i]); end
    end
    for (int i = 0; i < dexp_md.size() && i < dgot_md.size(); i++) begin
      checks++; if (dgot_md[i] !== dexp_md[i] || dgot_phv[i] !== dexp_phv[i]) begin errors++; $display("FAIL rand_drop_pkt%0d: got %h expected %h", i, dgot_md[i], dexp_md[i]); end
    end
    checks++; if (got_key.size() != exp_key.size()) begin errors++; $display("FAIL rand_key_count: got %0d expected %0d", got_key.size(), exp_key.size()); end
    for (int i = 0; i < exp_key.size() && i < got_key.size(); i++) begin
      checks++; if (got_key[i] !== exp_key[i]) begin errors++; $display("FAIL rand_key%0d: got %h expected %h (low 64 bits)", i, got_key[i][63:0], exp_key[i][63:0]); end
    end
    checks++; if (hit_cnt != n_hit || miss_cnt != n_miss || drop_cnt != 0) begin errors++; $display("FAIL rand_cnt: got %0d/%0d/%0d expected %0d/%0d/0", hit_cnt, miss_cnt, drop_cnt, n_hit, n_miss); end
    checks++; if (d_drop_cnt != n_miss || d_hit_cnt != n_hit) begin errors++; $display("FAIL rand_drop_cnt: got %0d/%0d expected %0d/%0d", d_drop_cnt, d_hit_cnt, n_miss, n_hit); end
  endtask

  task automatic test_strobes();
    checks++; if (strobe_bad != 0) begin errors++; $display("FAIL strobe_pair: got %0d uneven cycles expected 0", strobe_bad); end
    checks++; if (zero_bad != 0) begin errors++; $display("FAIL idle_data_zero: got %0d nonzero cycles expected 0", zero_bad); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_match_hit();
    test_match_miss();
    test_backpressure();
    test_overflow();
    test_reset_wait_idx();
    test_random();
    test_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gme_mc.md
GME_MC -- requirements
Module: gme_mc

Interface
REQ-001 Parameter MD_W, default 256, metadata width.
REQ-002 Parameter PHV_W, default 1024, PHV width.
REQ-003 Parameter KEY_W, default 512, lookup key width.
REQ-004 Parameter IDX_W, default 13, lookup index width.
REQ-005 Parameter DEPTH_LOG2, default 8, MD/PHV/index FIFO depth = 2^DEPTH_LOG2.
REQ-006 Parameter MID_LSB, default 80, LSB of the 8-bit module-ID field in MD.
REQ-007 Parameter IDX_LSB, default 50, LSB of the index field written into MD; hit flag sits at IDX_LSB+IDX_W.
REQ-008 Parameter LMID, default 8'd3, this module's ID; NMID, default 8'd4, next module's ID.
REQ-009 Parameter MISS_DROP, default 0; 1 = discard matched packets whose lookup missed.
REQ-010 Clocking: one clock; reset is asynchronous and active-high.
REQ-011 clk  in  1  clock, all logic on rising edge.
REQ-012 rst  in  1  asynchronous active-high reset.
REQ-013 in_key_wr / in_key  in  1 / KEY_W  key strobe and data from previous module.
REQ-014 out_key_alf  out  1  key almost-full to previous module.
REQ-015 in_md_wr / in_md / in_phv_wr / in_phv  in  1 / MD_W / 1 / PHV_W  MD and PHV strobes and data.
REQ-016 out_md_alf / out_phv_alf  out  1 / 1  MD/PHV almost-full to previous module.
REQ-017 in_idx_wr / in_idx  in  1 / IDX_W+1  lookup result; bit IDX_W = hit.
REQ-018 out_idx_alf  out  1  index FIFO almost-full to lookup.
REQ-019 out_key_wr / out_key  out  1 / KEY_W  key to lookup; in_key_alf  in  1.
REQ-020 out_md_wr / out_md / out_phv_wr / out_phv  out  1 / MD_W / 1 / PHV_W  to next module; in_md_alf, in_phv_alf  in  1.
REQ-021 hit_cnt / miss_cnt / drop_cnt  out  32 each  statistics; ovf_err  out  1  sticky FIFO-overflow flag.

Function
REQ-022 out_key_wr/out_key SHALL register in_key_wr/in_key one cycle later only when in_key_wr=1 and in_md[MID_LSB+:8]==LMID; else out_key_wr=0, out_key holds.
REQ-023 out_key_alf SHALL equal in_key_alf combinationally.
REQ-024 MD, PHV, index FIFOs SHALL be show-ahead, depth 2^DEPTH_LOG2; a write to a full FIFO SHALL be discarded and set ovf_err.
REQ-025 out_md_alf = in_md_alf OR MD used > 2^DEPTH_LOG2-6; out_phv_alf likewise with in_phv_alf and PHV used; out_idx_alf = index used > 2^DEPTH_LOG2-6.
REQ-026 FSM states IDLE, WAIT_IDX, EMIT.
REQ-027 IDLE: when MD and PHV non-empty and in_md_alf=0 and in_phv_alf=0 -> head MID==LMID ? WAIT_IDX : pop MD+PHV, EMIT(pass).
REQ-028 WAIT_IDX: when index FIFO non-empty, pop MD+PHV+index together, go EMIT(match); otherwise stay, no timeout.
REQ-029 EMIT(pass): out_md=popped MD unchanged, out_phv=popped PHV, out_md_wr=out_phv_wr=1 for one cycle, return IDLE.
REQ-030 EMIT(match): out_md=popped MD with MID field:=NMID, [IDX_LSB+:IDX_W]:=idx, bit IDX_LSB+IDX_W:=hit; other bits unchanged; hit increments hit_cnt else miss_cnt.
REQ-031 EMIT(match) with hit=0 and MISS_DROP=1: no write strobes, drop_cnt increments; packet consumed.
REQ-032 Write strobes SHALL be single-cycle and always coincident for MD and PHV; data outputs are zero when strobes low.
REQ-033 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-034 Throughput: at most one packet per 2 cycles (pass) or 3 cycles (match, index already present).
REQ-035 Parameters violating MID_LSB+8>MD_W or IDX_LSB+IDX_W+1>MD_W SHALL be a configuration error (elaboration failure).

Reset
REQ-036 rst=1 SHALL immediately clear all outputs, counters, ovf_err, FIFOs, FSM to IDLE; reset mid-packet discards that packet with no partial strobe.

Verification
REQ-037 Pass-through: MD MID=8'd7 + PHV -> out_md equals input, out_md_wr=out_phv_wr=1 two cycles after FIFO write, no out_key_wr.
REQ-038 Match hit: MD MID=3, key=K, then idx={1,13'h1A5} -> out_key=K; out_md MID=8'd4, [62:50]=13'h1A5, bit63=1; hit_cnt=1.
REQ-039 Match miss with MISS_DROP=1 -> no out_md_wr, drop_cnt=1, miss_cnt=1; MISS_DROP=0 -> emitted with bit63=0.
REQ-040 Backpressure: hold in_md_alf=1 with 3 packets queued -> no output; release -> 3 packets in order.
REQ-041 Overflow: 2^DEPTH_LOG2+1 MD writes with output stalled -> out_md_alf=1 at used=251, ovf_err=1, last write lost.
REQ-042 Assert rst while in WAIT_IDX -> all outputs 0, FIFOs empty, next packet processed normally.
